// File: rtl/video_timing_gen.sv
// Pixel-clock raster timing generator: counters, aligned sync/de flags and a
// per-line prefetch handshake toward the line-buffer logic.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PREFETCH = 64
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        enable,
  output logic [10:0] h_cnt,
  output logic [9:0]  v_cnt,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic        frame_start,
  output logic        line_req,
  output logic [9:0]  line_req_y,
  input  logic        line_ack,
  output logic        underrun
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT        = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_REQ_POINT  = 11'(H_TOTAL - PREFETCH);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    REQ_IDLE,
    REQ_PEND
  } req_state_t;

  logic [10:0] h_next;
  logic [9:0]  v_next;
  logic [9:0]  next_line;
  logic        req_hit;
  logic        late;
  req_state_t  req_state;
  req_state_t  req_next;

  // Counter values one pixel ahead; flags are decoded from these so they are
  // registered in the same edge as the counters and never skew against them.
  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // some path leaves it unassigned and a latch is inferred.
  always_comb begin
    h_next = h_cnt + 11'd1;
    v_next = v_cnt;
    if (h_cnt == H_LAST) begin
      h_next = '0;
      v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
  end

  always_comb begin
    next_line = (v_next == V_LAST) ? '0 : v_next + 10'd1;
    req_hit   = enable && (h_next == H_REQ_POINT) && (next_line < V_ACT);
    // Request still outstanding when its own line has begun.
    late      = (req_state == REQ_PEND) && (h_cnt == '0) && (v_cnt == line_req_y);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      hs          <= ((h_next >= H_SYNC_START) && (h_next < H_SYNC_END)) ? HS_POL : ~HS_POL;
      vs          <= ((v_next >= V_SYNC_START) && (v_next < V_SYNC_END)) ? VS_POL : ~VS_POL;
      de          <= (h_next < H_ACT) && (v_next < V_ACT);
      frame_start <= (h_next == '0) && (v_next == '0);
    end else begin
      frame_start <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      req_state <= REQ_IDLE;
    end else begin
      req_state <= req_next;
    end
  end

  // An underrun abandons the request and takes priority over a same-cycle ack.
  always_comb begin
    req_next = req_state;
    unique case (req_state)
      REQ_IDLE: if (req_hit) req_next = REQ_PEND;
      REQ_PEND: begin
        if (late) begin
          req_next = REQ_IDLE;
        end else if (line_ack) begin
          req_next = REQ_IDLE;
        end
      end
      default: req_next = REQ_IDLE;
    endcase
  end

  always_comb begin
    line_req = (req_state == REQ_PEND);
  end

  // The PEND state is what arms the underrun check, so no separate flag is
  // needed and line 0 of the first frame after reset is exempt.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      line_req_y <= '0;
      underrun   <= 1'b0;
    end else begin
      if ((req_state == REQ_IDLE) && req_hit) begin
        line_req_y <= next_line;
      end
      if (late) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a 16x7 raster with a behavioural
// model predicting every output on every clock.
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HSW = 2, HB = 4;
  localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
  localparam int PF = 4;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        enable;
  logic        line_ack;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        hs, vs, de, frame_start, line_req, underrun;
  logic [9:0]  line_req_y;

  logic ack_d  = 1'b0;
  logic ack_en = 1'b1;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .PREFETCH(PF)
  ) dut (
    .clk(clk), .n_reset(n_reset), .enable(enable),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .hs(hs), .vs(vs), .de(de),
    .frame_start(frame_start), .line_req(line_req), .line_req_y(line_req_y),
    .line_ack(line_ack), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Line-buffer stand-in: acknowledges one cycle after it sees a request.
  always @(posedge clk) ack_d <= line_req;
  assign line_ack = ack_en & ack_d;

  typedef struct {
    int    h;
    int    v;
    bit    hs;
    bit    vs;
    bit    de;
    bit    fs;
    bit    req;
    int    req_y;
    bit    und;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int mh, mv, mreq_y;
  bit mhs, mvs, mde, mfs, mreq, mund;

  task automatic model_reset();
    mh = HT - 1; mv = VT - 1;
    mhs = 1'b0; mvs = 1'b0; mde = 1'b0; mfs = 1'b0;
    mreq = 1'b0; mreq_y = 0; mund = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit ack);
    bit was_req;
    was_req = mreq;
    if (mreq) begin
      if (mh == 0 && mv == mreq_y) begin
        mreq = 1'b0;
        mund = 1'b1;
      end else if (ack) begin
        mreq = 1'b0;
      end
    end
    if (en) begin
      mh = mh + 1;
      if (mh == HT) begin
        mh = 0;
        mv = (mv + 1) % VT;
      end
      mhs = (mh >= HA + HF) && (mh < HA + HF + HSW);
      mvs = (mv >= VA + VF) && (mv < VA + VF + VSW);
      mde = (mh < HA) && (mv < VA);
      mfs = (mh == 0) && (mv == 0);
      if (!was_req && mh == HT - PF && ((mv + 1) % VT) < VA) begin
        mreq   = 1'b1;
        mreq_y = (mv + 1) % VT;
      end
    end else begin
      mfs = 1'b0;
    end
  endtask

  // One pixel clock: drive enable, predict, then compare just after the edge.
  task automatic cycle(input bit en, input string tag);
    exp_t e;
    @(negedge clk);
    enable = en;
    model_step(en, line_ack);
    e = '{mh, mv, mhs, mvs, mde, mfs, mreq, mreq_y, mund, tag};
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      if ({h_cnt, v_cnt, hs, vs, de, frame_start, line_req, line_req_y, underrun} !==
          {11'(e.h), 10'(e.v), e.hs, e.vs, e.de, e.fs, e.req, 10'(e.req_y), e.und}) begin
        errors++;
        $display("FAIL %s got h=%0d v=%0d hs=%b vs=%b de=%b fs=%b req=%b y=%0d und=%b want h=%0d v=%0d hs=%b vs=%b de=%b fs=%b req=%b y=%0d und=%b",
                 e.tag, h_cnt, v_cnt, hs, vs, de, frame_start, line_req, line_req_y, underrun,
                 e.h, e.v, e.hs, e.vs, e.de, e.fs, e.req, e.req_y, e.und);
      end
    end
  endtask

  // Assert reset wherever we are, check reset values at once, then release
  // and take the first enabled pixel.
  task automatic do_reset(input string tag);
    n_reset = 1'b0;
    enable  = 1'b0;
    #1;
    checks++;
    if ({h_cnt, v_cnt, hs, vs, de, frame_start, line_req, line_req_y, underrun} !==
        {11'(HT - 1), 10'(VT - 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0}) begin
      errors++;
      $display("FAIL %s reset_values got h=%0d v=%0d hs=%b vs=%b de=%b fs=%b req=%b y=%0d und=%b want h=%0d v=%0d rest 0",
               tag, h_cnt, v_cnt, hs, vs, de, frame_start, line_req, line_req_y, underrun, HT - 1, VT - 1);
    end
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    n_reset = 1'b1;
    cycle(1'b1, "first_pixel");
    checks++;
    if ({h_cnt, v_cnt, frame_start, de} !== {11'd0, 10'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL %s first_pixel got h=%0d v=%0d fs=%b de=%b want 0 0 1 1",
               tag, h_cnt, v_cnt, frame_start, de);
    end
  endtask

  task automatic test_reset();
    ack_en = 1'b1;
    do_reset("test_reset");
  endtask

  task automatic test_frame();
    int gap;
    gap = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      cycle(1'b1, "frame");
      gap++;
      if (frame_start) begin
        checks++;
        if (gap !== HT * VT) begin
          errors++;
          $display("FAIL frame_period got %0d want %0d", gap, HT * VT);
        end
        gap = 0;
      end
    end
  endtask

  task automatic test_request();
    do_reset("test_request");
    ack_en = 1'b1;
    for (int i = 0; i < HT * VT + 4; i++) begin
      cycle(1'b1, "request");
      if (v_cnt == 0 && h_cnt == 12) begin
        checks++;
        if ({line_req, line_req_y} !== {1'b1, 10'd1}) begin
          errors++;
          $display("FAIL req_line1 got req=%b y=%0d want 1 1", line_req, line_req_y);
        end
      end
      if (v_cnt == 0 && h_cnt == 14) begin
        checks++;
        if (line_req !== 1'b0) begin
          errors++;
          $display("FAIL req_drop got %b want 0", line_req);
        end
      end
      if (v_cnt == 6 && h_cnt == 12) begin
        checks++;
        if ({line_req, line_req_y} !== {1'b1, 10'd0}) begin
          errors++;
          $display("FAIL req_line0 got req=%b y=%0d want 1 0", line_req, line_req_y);
        end
      end
      if (v_cnt >= 3 && v_cnt <= 5 && line_req) begin
        checks++;
        errors++;
        $display("FAIL req_blank got req=1 at v=%0d h=%0d want 0", v_cnt, h_cnt);
      end
    end
  endtask

  task automatic test_underrun();
    do_reset("test_underrun");
    ack_en = 1'b0;
    for (int i = 0; i < 3 * HT * VT; i++) begin
      cycle(1'b1, "underrun");
      if (i < HT * VT && v_cnt == 1 && h_cnt == 0) begin
        checks++;
        if ({line_req, underrun} !== {1'b1, 1'b0}) begin
          errors++;
          $display("FAIL underrun_pending got req=%b und=%b want 1 0", line_req, underrun);
        end
      end
      if (i < HT * VT && v_cnt == 1 && h_cnt == 1) begin
        checks++;
        if ({line_req, underrun} !== {1'b0, 1'b1}) begin
          errors++;
          $display("FAIL underrun_set got req=%b und=%b want 0 1", line_req, underrun);
        end
      end
      if (i == 2 * HT * VT) ack_en = 1'b1;
    end
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky got %b want 1", underrun);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_enable_toggle();
    bit prev_fs;
    int req_len;
    do_reset("test_enable");
    prev_fs = frame_start;
    req_len = 0;
    for (int i = 0; i < 2 * HT * VT + 8; i++) begin
      cycle(i[0], "enable_toggle");
      if (frame_start) begin
        checks++;
        if (prev_fs) begin
          errors++;
          $display("FAIL fs_width got 2 cycles want 1");
        end
      end
      prev_fs = frame_start;
      if (line_req) begin
        req_len++;
      end else if (req_len != 0) begin
        checks++;
        if (req_len !== 2) begin
          errors++;
          $display("FAIL req_len_gated got %0d want 2", req_len);
        end
        req_len = 0;
      end
    end
  endtask

  task automatic test_reset_mid_request();
    bit found;
    do_reset("test_midreq_pre");
    found = 1'b0;
    for (int i = 0; i < 2 * HT * VT && !found; i++) begin
      cycle(1'b1, "midreq");
      if (h_cnt == 13 && v_cnt == 0) found = 1'b1;
    end
    checks++;
    if (!found || line_req !== 1'b1) begin
      errors++;
      $display("FAIL midreq_setup got found=%b req=%b want 1 1", found, line_req);
    end
    #2;
    do_reset("test_midreq");
    for (int i = 0; i < 20; i++) cycle(1'b1, "after_midreq");
  endtask

  initial begin
    n_reset = 1'b1;
    enable  = 1'b0;
    #3;
    test_reset();
    test_frame();
    test_request();
    test_underrun();
    test_enable_toggle();
    test_reset_mid_request();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
